// File: rtl/biu_slave_ram_if.sv
// Bus-side interface shared by every BIU slave: request fields from the BIU, response back.
interface biu_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rnw;
  logic                  en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;

  modport device (
    input  address,
    input  data_in,
    input  rnw,
    input  en,
    output data_out,
    output data_valid
  );

  modport host (
    output address,
    output data_in,
    output rnw,
    output en,
    input  data_out,
    input  data_valid
  );
endinterface

// File: rtl/biu_slave_ram.sv
// biu_slave_ram: word-addressed RAM slave behind the BIU.
// - Decodes a RAM_DEPTH-word window at BASE_ADDR; misses are ignored entirely.
// - Writes land at the accepting edge; reads return after READ_LATENCY cycles, no stall.
// - Memory is read at the last pipeline stage, so earlier writes are always visible.
// - Outputs are zero when not returning data, allowing OR-combining of slaves.
// Optional feature: define BIU_SLAVE_RAM_STATS_EN to add saturating rd_count/wr_count.
module biu_slave_ram #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           RAM_DEPTH    = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int unsigned           READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  biu_slave_if.device slave_if
`ifdef BIU_SLAVE_RAM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int unsigned IDX_W = $clog2(RAM_DEPTH);

  // Parameter sanity checks at elaboration
  if (RAM_DEPTH < 2 || (RAM_DEPTH & (RAM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("biu_slave_ram: RAM_DEPTH must be a power of two >= 2");
  end
  if ((BASE_ADDR % RAM_DEPTH) != 0) begin : g_bad_base
    $error("biu_slave_ram: BASE_ADDR must be aligned to RAM_DEPTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_lat
    $error("biu_slave_ram: READ_LATENCY must be in 1..8");
  end

  logic                  hit;
  logic                  rd_hit;
  logic                  wr_hit;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic [READ_LATENCY-1:0] vld_q;
  logic [IDX_W-1:0]        tag_idx_q [READ_LATENCY];

  // Window decode; requests seen while reset is high never take effect
  always_comb begin
    hit    = slave_if.en && !rst &&
             (slave_if.address[ADDR_WIDTH-1:IDX_W] == BASE_ADDR[ADDR_WIDTH-1:IDX_W]);
    idx    = slave_if.address[IDX_W-1:0];
    rd_hit = hit && slave_if.rnw;
    wr_hit = hit && !slave_if.rnw;
  end

  // Storage: deliberately no reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[idx] <= slave_if.data_in;
    end
  end

  // Read-tag valid pipeline; reset drops in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_hit;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Read-tag index pipeline; only meaningful alongside vld_q
  always_ff @(posedge clk) begin
    tag_idx_q[0] <= idx;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_idx_q[i] <= tag_idx_q[i-1];
    end
  end

  // Response: sample memory at the final stage, force zero when idle
  always_comb begin
    slave_if.data_valid = vld_q[READ_LATENCY-1];
    slave_if.data_out   = '0;
    if (vld_q[READ_LATENCY-1]) begin
      slave_if.data_out = mem[tag_idx_q[READ_LATENCY-1]];
    end
  end

`ifdef BIU_SLAVE_RAM_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  // Saturating counters of accepted hit reads and writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (rd_hit && rd_count_q != 16'hFFFF) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
      if (wr_hit && wr_count_q != 16'hFFFF) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  // Counter outputs
  always_comb begin
    rd_count = rd_count_q;
    wr_count = wr_count_q;
  end
`endif

endmodule

// File: tb/tb_biu_slave_ram.sv
// Testbench for biu_slave_ram: vector table plus scoreboard of expected read returns.
module tb_biu_slave_ram;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  biu_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef BIU_SLAVE_RAM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  biu_slave_ram #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .RAM_DEPTH   (DEPTH),
    .BASE_ADDR   (BASE),
    .READ_LATENCY(LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .slave_if(bus)
`ifdef BIU_SLAVE_RAM_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        en;
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] model [DEPTH];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;

  task automatic check_out();
    total++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (bus.data_valid !== 1'b1 || bus.data_out !== sb[0].data) begin
        bad++;
        $display("FAIL read_return cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                 cyc, bus.data_valid, bus.data_out, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (bus.data_valid !== 1'b0 || bus.data_out !== '0) begin
      bad++;
      $display("FAIL idle_zero cyc=%0d got valid=%b data=%h want valid=0 data=0",
               cyc, bus.data_valid, bus.data_out);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_out();
  endtask

  task automatic drive(input logic en, input logic rnw, input logic [31:0] addr,
                       input logic [31:0] data);
    logic       hit;
    logic [7:0] idx;
    exp_t       e;
    bus.en      = en;
    bus.rnw     = rnw;
    bus.address = addr;
    bus.data_in = data;
    hit = en && !rst && ((addr >> 8) == (BASE >> 8));
    idx = addr[7:0];
    if (hit && rnw) begin
      e.data = model[idx];
      e.due  = cyc + LAT;
      sb.push_back(e);
      if (exp_rd < 65535) exp_rd++;
    end else if (hit) begin
      model[idx] = data;
      if (exp_wr < 65535) exp_wr++;
    end
    tick();
    bus.en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_drained();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drained cyc=%0d got pending=%0d want pending=0", cyc, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_stats(input string name, input int want_rd, input int want_wr);
`ifdef BIU_SLAVE_RAM_STATS_EN
    total++;
    if (rd_count !== want_rd[15:0] || wr_count !== want_wr[15:0]) begin
      bad++;
      $display("FAIL %s got rd=%h wr=%h want rd=%h wr=%h", name, rd_count, wr_count,
               want_rd[15:0], want_wr[15:0]);
    end
`endif
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    sb.delete();
    exp_rd = 0;
    exp_wr = 0;
    #1;
    check_out();
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.rnw     = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    #1;
    check_out();
    for (int i = 0; i < 3; i++) tick();
    check_stats("reset_stats", 0, 0);
    rst = 1'b0;

    // Main vector table: model memory supplies every read expectation
    vecs.push_back('{1'b1, 1'b0, BASE + 32'd5,   32'hDEADBEEF});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          32'h0});
    vecs.push_back('{1'b1, 1'b1, BASE + 32'd5,   32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          32'h0});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 1'b0, BASE + i, 32'h10 + i});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 1'b1, BASE + i, 32'h0});
    vecs.push_back('{1'b1, 1'b0, BASE + 32'd7,   32'h000000A5});
    vecs.push_back('{1'b1, 1'b1, BASE + 32'd7,   32'h0});
    vecs.push_back('{1'b1, 1'b0, BASE + 32'd255, 32'hCAFE0255});
    vecs.push_back('{1'b1, 1'b0, BASE + DEPTH,   32'hBAD00000});
    vecs.push_back('{1'b1, 1'b0, BASE - 32'd1,   32'hBAD00001});
    vecs.push_back('{1'b1, 1'b1, BASE + DEPTH,   32'h0});
    vecs.push_back('{1'b1, 1'b1, BASE - 32'd1,   32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          32'h0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,          32'h0});
    vecs.push_back('{1'b1, 1'b1, BASE,           32'h0});
    vecs.push_back('{1'b1, 1'b1, BASE + 32'd255, 32'h0});
    vecs.push_back('{1'b0, 1'b1, BASE + 32'd1,   32'h0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].rnw, vecs[i].addr, vecs[i].data);
    end
    idle(LAT + 1);
    check_drained();
    check_stats("table_stats", exp_rd, exp_wr);

    // Write lands while a read of the same word is still in flight
    drive(1'b1, 1'b0, BASE + 32'd9, 32'h00000099);
    drive(1'b1, 1'b1, BASE + 32'd9, 32'h0);
    e = sb.pop_back();
    e.data = 32'h00001234;
    sb.push_back(e);
    drive(1'b1, 1'b0, BASE + 32'd9, 32'h00001234);
    idle(LAT + 1);
    check_drained();

    // Reset with two reads outstanding: both dropped, memory kept
    drive(1'b1, 1'b1, BASE + 32'd0, 32'h0);
    bus.en      = 1'b1;
    bus.rnw     = 1'b1;
    bus.address = BASE + 32'd1;
    @(posedge clk);
    cyc++;
    #1;
    bus.en = 1'b0;
    do_reset(2);
    check_stats("reset_mid_stats", 0, 0);
    rst = 1'b1;
    drive(1'b1, 1'b0, BASE + 32'd0, 32'hFFFFFFFF);
    rst = 1'b0;
    idle(LAT + 1);
    drive(1'b1, 1'b1, BASE + 32'd0, 32'h0);
    drive(1'b1, 1'b1, BASE + 32'd1, 32'h0);
    drive(1'b1, 1'b1, BASE + 32'd5, 32'h0);
    idle(LAT + 1);
    check_drained();

    // Counter sequence from a fresh reset
    do_reset(1);
    drive(1'b1, 1'b1, BASE + 32'd2, 32'h0);
    drive(1'b1, 1'b0, BASE + 32'd20, 32'h00000020);
    drive(1'b1, 1'b1, BASE + 32'd3, 32'h0);
    drive(1'b1, 1'b1, BASE + DEPTH, 32'h0);
    drive(1'b1, 1'b0, BASE + 32'd21, 32'h00000021);
    drive(1'b1, 1'b1, BASE + 32'd20, 32'h0);
    idle(LAT + 1);
    check_drained();
    check_stats("stats_3r_2w", 3, 2);

`ifdef BIU_SLAVE_RAM_STATS_EN
    while (exp_rd < 65535) drive(1'b1, 1'b1, BASE + 32'd21, 32'h0);
    idle(LAT + 1);
    check_stats("stats_reach_max", 65535, 2);
    drive(1'b1, 1'b1, BASE + 32'd21, 32'h0);
    idle(LAT + 1);
    check_stats("stats_saturate", 65535, 2);
    check_drained();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
